image_write_sequencer: RTL and testbench

Raster-order controller that sits between the image-processing pipeline's pixel stream and the BMP image writer. It accepts RGB pixels over a valid/ready handshake and generates the writer's `rowIndex`/`colIndex`/`writeBackImage` strobes and registered pixel data. It tracks frame progress and waits for the writer's `Write_Done` before reporting completion. A compile-time option burns a detection bounding box into the written frame.

---
 rtl/image_write_sequencer_pkg.sv | 18 +
 rtl/image_write_sequencer_if.sv | 46 ++++
 rtl/image_write_sequencer_raster_counter.sv | 43 ++++
 rtl/image_write_sequencer.sv | 177 +++++++++++++++++
 tb/tb_image_write_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/image_write_sequencer_pkg.sv
// Shared types and constants for the image write sequencer.
// Overlay colour constants are used only when IMAGE_WRITE_SEQ_OVERLAY_EN is defined.
package image_write_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_DONE      = 2'd3
    } seq_state_t;

    // Overlay colour per channel: 1 = channel saturated, 0 = channel zero.
    // These are replicated to the channel width, which keeps them width-agnostic.
    localparam bit OVL_R_SAT = 1'b1;
    localparam bit OVL_G_SAT = 1'b0;
    localparam bit OVL_B_SAT = 1'b0;

endpackage

// File: rtl/image_write_sequencer_if.sv
// Pixel stream, writer bus, control and overlay-box signals for the sequencer.
// master = sequencer side, slave = pipeline/writer/host side.
interface image_write_sequencer_if #(
    parameter int BITS_FOR_INDEX = 10,
    parameter int sizeOfWidth    = 8
);
    logic                      start;
    logic                      abort;
    logic                      in_valid;
    logic [sizeOfWidth-1:0]    in_r;
    logic [sizeOfWidth-1:0]    in_g;
    logic [sizeOfWidth-1:0]    in_b;
    logic                      in_ready;
    logic [BITS_FOR_INDEX-1:0] box_row0;
    logic [BITS_FOR_INDEX-1:0] box_row1;
    logic [BITS_FOR_INDEX-1:0] box_col0;
    logic [BITS_FOR_INDEX-1:0] box_col1;
    logic                      box_valid;
    logic [BITS_FOR_INDEX-1:0] rowIndex;
    logic [BITS_FOR_INDEX-1:0] colIndex;
    logic                      writeBackImage;
    logic [sizeOfWidth-1:0]    DATA_WRITE_R0;
    logic [sizeOfWidth-1:0]    DATA_WRITE_G0;
    logic [sizeOfWidth-1:0]    DATA_WRITE_B0;
    logic                      Write_Done;
    logic                      busy;
    logic                      frame_done;

    modport master (
        input  start, abort, in_valid, in_r, in_g, in_b,
        input  box_row0, box_row1, box_col0, box_col1, box_valid,
        input  Write_Done,
        output in_ready, rowIndex, colIndex, writeBackImage,
        output DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
        output busy, frame_done
    );

    modport slave (
        output start, abort, in_valid, in_r, in_g, in_b,
        output box_row0, box_row1, box_col0, box_col1, box_valid,
        output Write_Done,
        input  in_ready, rowIndex, colIndex, writeBackImage,
        input  DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
        input  busy, frame_done
    );
endinterface

// File: rtl/image_write_sequencer_raster_counter.sv
// Raster row/col counter: holds the address of the next pixel to be accepted.
module raster_counter #(
    parameter int WIDTH          = 768,
    parameter int HEIGHT         = 512,
    parameter int BITS_FOR_INDEX = 10
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clear,
    input  logic                      i_inc,
    output logic [BITS_FOR_INDEX-1:0] o_row,
    output logic [BITS_FOR_INDEX-1:0] o_col,
    output logic                      o_last
);
    localparam logic [BITS_FOR_INDEX-1:0] COL_LAST = BITS_FOR_INDEX'(WIDTH - 1);
    localparam logic [BITS_FOR_INDEX-1:0] ROW_LAST = BITS_FOR_INDEX'(HEIGHT - 1);
    localparam logic [BITS_FOR_INDEX-1:0] ONE      = BITS_FOR_INDEX'(1);

    logic [BITS_FOR_INDEX-1:0] r_row;
    logic [BITS_FOR_INDEX-1:0] r_col;

    // Advance column, wrapping into the next row at the right edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_inc) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + ONE;
            end else begin
                r_col <= r_col + ONE;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == ROW_LAST) && (r_col == COL_LAST);
endmodule

// File: rtl/image_write_sequencer.sv
// Raster-order write sequencer between the pixel pipeline and the BMP writer.
// Optional bounding-box overlay: define IMAGE_WRITE_SEQ_OVERLAY_EN.
//
// state        | meaning
// -------------+----------------------------------------------------
// ST_IDLE      | waiting for start, in_ready low
// ST_RUN       | accepting pixels in raster order
// ST_WAIT_DONE | last pixel accepted, waiting for writer Write_Done
// ST_DONE      | one cycle, frame_done high
module image_write_sequencer
    import image_write_seq_pkg::*;
#(
    parameter int WIDTH          = 768,
    parameter int HEIGHT         = 512,
    parameter int BITS_FOR_INDEX = 10,
    parameter int sizeOfWidth    = 8
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    image_write_sequencer_if.master bus
);
    seq_state_t                r_state;
    logic                      r_in_ready;
    logic                      r_busy;
    logic                      r_frame_done;
    logic                      r_wstrobe;
    logic [BITS_FOR_INDEX-1:0] r_row_idx;
    logic [BITS_FOR_INDEX-1:0] r_col_idx;
    logic [sizeOfWidth-1:0]    r_data_r;
    logic [sizeOfWidth-1:0]    r_data_g;
    logic [sizeOfWidth-1:0]    r_data_b;

    logic                      w_start;
    logic                      w_accept;
    logic [BITS_FOR_INDEX-1:0] w_row;
    logic [BITS_FOR_INDEX-1:0] w_col;
    logic                      w_last;
    logic [sizeOfWidth-1:0]    w_pix_r;
    logic [sizeOfWidth-1:0]    w_pix_g;
    logic [sizeOfWidth-1:0]    w_pix_b;

    // abort beats a same-cycle accept, so an aborted pixel is never written
    assign w_start  = (r_state == ST_IDLE) && bus.start;
    assign w_accept = (r_state == ST_RUN) && bus.in_valid && !bus.abort;

    raster_counter #(
        .WIDTH          (WIDTH),
        .HEIGHT         (HEIGHT),
        .BITS_FOR_INDEX (BITS_FOR_INDEX)
    ) u_raster (
        .i_clk   (HCLK),
        .i_rst_n (HRESETn),
        .i_clear (w_start),
        .i_inc   (w_accept),
        .o_row   (w_row),
        .o_col   (w_col),
        .o_last  (w_last)
    );

`ifdef IMAGE_WRITE_SEQ_OVERLAY_EN
    logic                      r_box_en;
    logic [BITS_FOR_INDEX-1:0] r_box_r0;
    logic [BITS_FOR_INDEX-1:0] r_box_r1;
    logic [BITS_FOR_INDEX-1:0] r_box_c0;
    logic [BITS_FOR_INDEX-1:0] r_box_c1;
    logic                      w_on_row;
    logic                      w_on_col;
    logic                      w_border;

    // Latch the box at frame start; a start without box_valid disables overlay.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_box_en <= 1'b0;
            r_box_r0 <= '0;
            r_box_r1 <= '0;
            r_box_c0 <= '0;
            r_box_c1 <= '0;
        end else if (w_start) begin
            r_box_en <= bus.box_valid;
            if (bus.box_valid) begin
                r_box_r0 <= bus.box_row0;
                r_box_r1 <= bus.box_row1;
                r_box_c0 <= bus.box_col0;
                r_box_c1 <= bus.box_col1;
            end
        end
    end

    assign w_on_row = ((w_row == r_box_r0) || (w_row == r_box_r1)) &&
                      (w_col >= r_box_c0) && (w_col <= r_box_c1);
    assign w_on_col = ((w_col == r_box_c0) || (w_col == r_box_c1)) &&
                      (w_row >= r_box_r0) && (w_row <= r_box_r1);
    assign w_border = r_box_en && (w_on_row || w_on_col);

    assign w_pix_r = w_border ? {sizeOfWidth{OVL_R_SAT}} : bus.in_r;
    assign w_pix_g = w_border ? {sizeOfWidth{OVL_G_SAT}} : bus.in_g;
    assign w_pix_b = w_border ? {sizeOfWidth{OVL_B_SAT}} : bus.in_b;
`else
    assign w_pix_r = bus.in_r;
    assign w_pix_g = bus.in_g;
    assign w_pix_b = bus.in_b;
`endif

    // Sequencer FSM with registered handshake, writer and status outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_wstrobe    <= 1'b0;
            r_row_idx    <= '0;
            r_col_idx    <= '0;
            r_data_r     <= '0;
            r_data_g     <= '0;
            r_data_b     <= '0;
        end else begin
            r_wstrobe    <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_accept) begin
                r_wstrobe <= 1'b1;
                r_row_idx <= w_row;
                r_col_idx <= w_col;
                r_data_r  <= w_pix_r;
                r_data_g  <= w_pix_g;
                r_data_b  <= w_pix_b;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        r_state    <= ST_IDLE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (w_accept && w_last) begin
                        r_state    <= ST_WAIT_DONE;
                        r_in_ready <= 1'b0;
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (bus.Write_Done) begin
                        r_state      <= ST_DONE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready       = r_in_ready;
    assign bus.busy           = r_busy;
    assign bus.frame_done     = r_frame_done;
    assign bus.writeBackImage = r_wstrobe;
    assign bus.rowIndex       = r_row_idx;
    assign bus.colIndex       = r_col_idx;
    assign bus.DATA_WRITE_R0  = r_data_r;
    assign bus.DATA_WRITE_G0  = r_data_g;
    assign bus.DATA_WRITE_B0  = r_data_b;
endmodule

// File: tb/tb_image_write_sequencer.sv
// Directed bench for image_write_sequencer with a 4x2 frame.
// Overlay expectations follow IMAGE_WRITE_SEQ_OVERLAY_EN.
module tb_image_write_sequencer;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int BI = 10;
    localparam int SW = 8;
`ifdef IMAGE_WRITE_SEQ_OVERLAY_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 HCLK = ~HCLK;

    image_write_sequencer_if #(.BITS_FOR_INDEX(BI), .sizeOfWidth(SW)) bus ();

    image_write_sequencer #(
        .WIDTH          (W),
        .HEIGHT         (H),
        .BITS_FOR_INDEX (BI),
        .sizeOfWidth    (SW)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_pix(input int k);
        bus.in_r = 8'(16 + k);
        bus.in_g = 8'(32 + k);
        bus.in_b = 8'(48 + k);
    endtask

    task automatic chk_write(input string tag, input int row, input int col,
                             input int r, input int g, input int b);
        chk({tag, "_strobe"}, 32'(bus.writeBackImage), 1);
        chk({tag, "_row"},    32'(bus.rowIndex), row);
        chk({tag, "_col"},    32'(bus.colIndex), col);
        chk({tag, "_r"},      32'(bus.DATA_WRITE_R0), r);
        chk({tag, "_g"},      32'(bus.DATA_WRITE_G0), g);
        chk({tag, "_b"},      32'(bus.DATA_WRITE_B0), b);
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.Write_Done = 0;
        bus.in_r = 0; bus.in_g = 0; bus.in_b = 0;
        bus.box_row0 = 0; bus.box_row1 = 0; bus.box_col0 = 0; bus.box_col1 = 0;
        bus.box_valid = 0;

        // reset values
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_busy",     32'(bus.busy), 0);
        chk("rst_done",     32'(bus.frame_done), 0);
        chk("rst_strobe",   32'(bus.writeBackImage), 0);
        chk("rst_row",      32'(bus.rowIndex), 0);
        chk("rst_col",      32'(bus.colIndex), 0);
        chk("rst_r",        32'(bus.DATA_WRITE_R0), 0);
        @(negedge HCLK);
        HRESETn = 1;

        // full frame, valid held high
        bus.start = 1; tick(); bus.start = 0;
        chk("ff_in_ready", 32'(bus.in_ready), 1);
        chk("ff_busy",     32'(bus.busy), 1);
        chk("ff_nostrobe", 32'(bus.writeBackImage), 0);
        bus.in_valid = 1;
        for (int k = 0; k < W * H; k++) begin
            set_pix(k); tick();
            chk_write("ff_px", k / W, k % W, 16 + k, 32 + k, 48 + k);
        end
        chk("ff_wait_ready", 32'(bus.in_ready), 0);
        chk("ff_wait_busy",  32'(bus.busy), 1);
        bus.in_valid = 0; tick();
        chk("ff_hold_strobe", 32'(bus.writeBackImage), 0);
        chk("ff_hold_row",    32'(bus.rowIndex), 1);
        chk("ff_hold_col",    32'(bus.colIndex), 3);
        chk("ff_hold_r",      32'(bus.DATA_WRITE_R0), 16 + 7);
        chk("ff_hold_done",   32'(bus.frame_done), 0);
        bus.Write_Done = 1; tick(); bus.Write_Done = 0;
        chk("ff_done_pulse", 32'(bus.frame_done), 1);
        chk("ff_done_busy",  32'(bus.busy), 0);
        tick();
        chk("ff_done_clear", 32'(bus.frame_done), 0);
        chk("ff_idle_ready", 32'(bus.in_ready), 0);

        // gapped valid 1,0,1,0
        bus.start = 1; tick(); bus.start = 0;
        bus.in_valid = 1; set_pix(0); tick();
        chk_write("gap0", 0, 0, 16, 32, 48);
        bus.in_valid = 0; tick();
        chk("gap1_strobe", 32'(bus.writeBackImage), 0);
        chk("gap1_col",    32'(bus.colIndex), 0);
        bus.in_valid = 1; set_pix(1); tick();
        chk_write("gap2", 0, 1, 17, 33, 49);
        bus.in_valid = 0; tick();
        chk("gap3_strobe", 32'(bus.writeBackImage), 0);

        // start mid-RUN is ignored
        bus.start = 1; tick(); bus.start = 0;
        chk("ign_busy",   32'(bus.busy), 1);
        chk("ign_ready",  32'(bus.in_ready), 1);
        chk("ign_strobe", 32'(bus.writeBackImage), 0);
        bus.in_valid = 1; set_pix(2); tick();
        chk_write("ign_px", 0, 2, 18, 34, 50);

        // abort with next pixel (1,1)
        set_pix(3); tick();
        set_pix(4); tick();
        chk_write("ab_pre", 1, 0, 20, 36, 52);
        bus.abort = 1; set_pix(5); tick(); bus.abort = 0; bus.in_valid = 0;
        chk("ab_strobe", 32'(bus.writeBackImage), 0);
        chk("ab_ready",  32'(bus.in_ready), 0);
        chk("ab_busy",   32'(bus.busy), 0);
        chk("ab_row",    32'(bus.rowIndex), 1);
        chk("ab_col",    32'(bus.colIndex), 0);
        bus.Write_Done = 1; tick(); bus.Write_Done = 0;
        chk("ab_wd_done", 32'(bus.frame_done), 0);
        tick();
        chk("ab_wd_done2", 32'(bus.frame_done), 0);
        bus.start = 1; tick(); bus.start = 0;
        bus.in_valid = 1; set_pix(6); tick(); bus.in_valid = 0;
        chk_write("ab_restart", 0, 0, 22, 38, 54);
        bus.abort = 1; tick(); bus.abort = 0;
        chk("ab2_busy", 32'(bus.busy), 0);

        // start and abort together in IDLE: start wins
        bus.start = 1; bus.abort = 1; tick(); bus.start = 0; bus.abort = 0;
        chk("sa_busy",  32'(bus.busy), 1);
        chk("sa_ready", 32'(bus.in_ready), 1);
        bus.in_valid = 1;
        for (int k = 0; k < W * H; k++) begin
            set_pix(k); tick();
        end
        bus.in_valid = 0;
        chk_write("sa_last", 1, 3, 23, 39, 55);
        chk("sa_wait_ready", 32'(bus.in_ready), 0);

        // abort and Write_Done together in WAIT_DONE
        bus.abort = 1; bus.Write_Done = 1; tick(); bus.abort = 0; bus.Write_Done = 0;
        chk("awd_busy",  32'(bus.busy), 0);
        chk("awd_done",  32'(bus.frame_done), 0);
        chk("awd_ready", 32'(bus.in_ready), 0);
        tick();
        chk("awd_done2", 32'(bus.frame_done), 0);

        // reset mid-frame clears immediately
        bus.start = 1; tick(); bus.start = 0;
        bus.in_valid = 1; set_pix(0); tick();
        chk("mr_strobe_pre", 32'(bus.writeBackImage), 1);
        #2 HRESETn = 0;
        #1;
        chk("mr_strobe", 32'(bus.writeBackImage), 0);
        chk("mr_busy",   32'(bus.busy), 0);
        chk("mr_ready",  32'(bus.in_ready), 0);
        chk("mr_r",      32'(bus.DATA_WRITE_R0), 0);
        bus.in_valid = 0;
        @(negedge HCLK);
        HRESETn = 1;
        tick();
        chk("mr_after_strobe", 32'(bus.writeBackImage), 0);
        chk("mr_after_done",   32'(bus.frame_done), 0);

        // overlay box (0,1)-(1,2); coordinates changed after start to prove capture
        bus.box_row0 = 0; bus.box_row1 = 1; bus.box_col0 = 1; bus.box_col1 = 2;
        bus.box_valid = 1; bus.start = 1; tick();
        bus.start = 0; bus.box_valid = 0;
        bus.box_row0 = 5; bus.box_row1 = 5; bus.box_col0 = 5; bus.box_col1 = 5;
        bus.in_valid = 1;
        for (int k = 0; k < W * H; k++) begin
            int col;
            col = k % W;
            set_pix(k); tick();
            if (OVL && (col == 1 || col == 2))
                chk_write("ovl_px", k / W, col, 255, 0, 0);
            else
                chk_write("ovl_px", k / W, col, 16 + k, 32 + k, 48 + k);
        end
        bus.in_valid = 0;
        bus.Write_Done = 1; tick(); bus.Write_Done = 0;
        chk("ovl_done", 32'(bus.frame_done), 1);
        tick();
        chk("ovl_done_clear", 32'(bus.frame_done), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
